shift_seq_unit: RTL and testbench
=================================

# shift_seq_unit

Parametrised multi-position shift engine for the datapath register file, successor to the single-step shift register. It loads a w-bit word, then, on a start command, shifts it by a programmable amount (0..2^AW−1 positions), one position per clock, in either direction and in one of four modes: logical, arithmetic, rotate, serial-in. A start/busy/done handshake lets a controller FSM sequence it.

## Interface
- w, default 8: data width, ≥ 2
- rst_val, default 0: value loaded into q on reset
- AW, default $clog2(w)+1: width of the shift-amount input
- clk  input  1  clock, rising edge
- rst_b  input  1  reset, asynchronous, active-low
- d  input  w  parallel load data
- ld  input  1  synchronous load, active high
- start  input  1  begin a shift operation, active high
- amt  input  AW  number of positions to shift
- dir  input  1  0 = right, 1 = left
- mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 serial-in
- si  input  1  serial input bit (mode 11)
- q  output  w  registered value
- so  output  1  last bit shifted out
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

## Operation
- Reset (rst_b=0, asynchronous): q=rst_val, so=0, busy=0, done=0, state IDLE, internal counter=0.
- States: IDLE and SHIFT. busy=1 exactly when state is SHIFT.
- IDLE, ld=1: q←d. ld has priority over start; a simultaneous start is dropped.
- IDLE, start=1, ld=0: capture amt, dir and mode into internal registers.
  - amt=0: stay in IDLE, q unchanged, done=1 next cycle.
  - amt>0: go to SHIFT, counter←amt.
- SHIFT, every edge: shift q one position using the captured dir and mode, then decrement the counter. so←the bit leaving q (q[0] for right, q[w-1] for left). When the counter reaches 1 at an edge, that edge performs the final shift, returns to IDLE and sets done=1 for the following cycle.
- Fill rules:
  - Right logical: fill with 0.
  - Right arithmetic: replicate q[w-1].
  - Rotate: fill with the bit shifted out.
  - Serial: fill with si, sampled each shift edge.
  - Left arithmetic is identical to left logical (fill 0).
- ld, start, amt, dir and mode are ignored while busy=1. A mid-operation change of dir or mode has no effect.
- amt ≥ w is legal. Logical shifts yield all fill bits; rotate wraps modulo w.
- done is a registered pulse. A new start or ld is accepted in the same cycle done is high.
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is produced.

## Timing
- start sampled at edge E0. busy=1 after E0. q updates at edges E1..Eamt. After Eamt, busy=0 and done=1 for one cycle.
- Latency from start edge to final q is amt cycles. amt=0 produces done after E0 with q unchanged.
- Back-to-back: start may be asserted during the done cycle. The next operation begins at that edge with no idle gap.
- ld latency is one edge. q never changes while in IDLE without ld.
- so holds its value between shifts. ld does not modify so.

## Structure
- Package shift_seq_pkg holds:
  - mode encodings MODE_LOG, MODE_ARI, MODE_ROT, MODE_SER.
  - state enum {S_IDLE, S_SHIFT}.
  - direction constants DIR_R, DIR_L.
- Sub-module shift_step (combinational, parametrised by w): inputs q, dir, mode, si; outputs next_q and out_bit. It is instantiated once. Control FSM, counter and capture registers live in shift_seq_unit.

## Test plan
- Reset with rst_val=8'hA5: assert rst_b=0 mid-cycle → q=8'hA5, busy=0, done=0, so=0 immediately, without waiting for a clock edge.
- Load 8'b1001_0110, then start, amt=3, dir=right, mode=arithmetic → busy high for 3 cycles; q=8'b1111_0010; so=1; done pulse one cycle.
- Load 8'b1000_0001, then start, amt=2, dir=left, mode=rotate → q=8'b0000_0110; so=0. Then start with amt=9, same dir and mode → q=8'b0000_1100 (9 mod 8 = 1).
- Load 8'h00, then start, amt=4, dir=left, mode=serial, with si driven 1,0,1,1 on successive edges → q=8'h0B.
- Corner cases:
  - amt=0 → done the next cycle, busy never high, q unchanged.
  - ld=1 and start=1 in the same cycle → only the load happens.
  - ld pulse while busy → ignored.
- Reset mid-shift (amt=5, after 2 shifts) → q=rst_val, busy=0, no done. Then start back-to-back during a done cycle → second operation runs without a gap.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-position shift engine.
package shift_seq_pkg;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_SER = 2'b11;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-position shift: computes the next word and the bit that leaves it.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int w = 8
) (
  input  logic [w-1:0] q,
  input  logic         dir,
  input  logic [1:0]   mode,
  input  logic         si,
  output logic [w-1:0] next_q,
  output logic         out_bit
);

  logic fill;

  always_comb begin
    out_bit = (dir == DIR_L) ? q[w-1] : q[0];
    fill    = 1'b0;
    unique case (mode)
      MODE_LOG: fill = 1'b0;
      // arithmetic only sign-extends going right; left behaves as logical
      MODE_ARI: fill = (dir == DIR_L) ? 1'b0 : q[w-1];
      MODE_ROT: fill = out_bit;
      MODE_SER: fill = si;
      default:  fill = 1'b0;
    endcase
    if (dir == DIR_L) next_q = {q[w-2:0], fill};
    else              next_q = {fill, q[w-1:1]};
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-position shift engine: one position per clock, start/busy/done handshake.
// state   | meaning
// S_IDLE  | waiting; accepts ld (priority) or start
// S_SHIFT | shifting one position per edge until the counter expires
module shift_seq_unit
  import shift_seq_pkg::*;
#(
  parameter int           w       = 8,
  parameter logic [w-1:0] rst_val = '0,
  parameter int           AW      = $clog2(w) + 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [w-1:0]  d,
  input  logic          ld,
  input  logic          start,
  input  logic [AW-1:0] amt,
  input  logic          dir,
  input  logic [1:0]    mode,
  input  logic          si,
  output logic [w-1:0]  q,
  output logic          so,
  output logic          busy,
  output logic          done
);

  state_t        state, state_nx;
  logic [AW-1:0] cnt;
  logic          dir_r;
  logic [1:0]    mode_r;
  logic [w-1:0]  step_q;
  logic          step_out;
  logic          last_shift;

  assign last_shift = (cnt == AW'(1));

  shift_step #(.w(w)) u_step (
    .q       (q),
    .dir     (dir_r),
    .mode    (mode_r),
    .si      (si),
    .next_q  (step_q),
    .out_bit (step_out)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!ld && start && (amt != '0)) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (last_shift) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q      <= rst_val;
      so     <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      dir_r  <= DIR_R;
      mode_r <= MODE_LOG;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (ld) begin
          q <= d;
        end else if (start) begin
          dir_r  <= dir;
          mode_r <= mode;
          cnt    <= amt;
          // a zero-length shift completes immediately without entering S_SHIFT
          if (amt == '0) done <= 1'b1;
        end
      end else begin
        q   <= step_q;
        so  <= step_out;
        cnt <= cnt - AW'(1);
        if (last_shift) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit with hand-computed expectations.
module tb_shift_seq_unit;

  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst_b;
  logic [W-1:0]  d;
  logic          ld, start, dir, si;
  logic [AW-1:0] amt;
  logic [1:0]    mode;
  logic [W-1:0]  q;
  logic          so, busy, done;

  int tests = 0;
  int fails = 0;

  shift_seq_unit #(.w(W), .rst_val(8'hA5), .AW(AW)) dut (
    .clk(clk), .rst_b(rst_b), .d(d), .ld(ld), .start(start), .amt(amt),
    .dir(dir), .mode(mode), .si(si), .q(q), .so(so), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0; d = '0; ld = 0; start = 0; amt = '0; dir = 0; mode = 2'b00; si = 0;
    #12 rst_b = 1'b1;
    step();

    // async reset mid-cycle
    d = 8'h3C; ld = 1; step(); ld = 0;
    chk("load_3c", q, 8'h3C);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_q", q, 8'hA5);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_so", so, 0);
    #1 rst_b = 1'b1;
    step();

    // right arithmetic by 3
    d = 8'b1001_0110; ld = 1; step(); ld = 0;
    chk("ari_load", q, 8'h96);
    start = 1; amt = 3; dir = 0; mode = 2'b01; step(); start = 0;
    chk("ari_e0_busy", busy, 1);
    chk("ari_e0_q", q, 8'h96);
    step();
    chk("ari_e1_q", q, 8'hCB);
    chk("ari_e1_busy", busy, 1);
    step();
    chk("ari_e2_q", q, 8'hE5);
    chk("ari_e2_busy", busy, 1);
    step();
    chk("ari_q", q, 8'hF2);
    chk("ari_busy_end", busy, 0);
    chk("ari_done", done, 1);
    chk("ari_so", so, 1);
    step();
    chk("ari_done_pulse", done, 0);
    chk("ari_q_hold", q, 8'hF2);

    // left rotate by 2, then back-to-back by 9
    d = 8'h81; ld = 1; step(); ld = 0;
    start = 1; amt = 2; dir = 1; mode = 2'b10; step(); start = 0;
    step();
    chk("rot_e1_q", q, 8'h03);
    chk("rot_e1_so", so, 1);
    step();
    chk("rot_q", q, 8'h06);
    chk("rot_so", so, 0);
    chk("rot_done", done, 1);
    start = 1; amt = 9; dir = 1; mode = 2'b10; step(); start = 0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    repeat (8) step();
    chk("rot9_busy_last", busy, 1);
    step();
    chk("rot9_q", q, 8'h0C);
    chk("rot9_so", so, 0);
    chk("rot9_done", done, 1);

    // serial-in left by 4
    d = 8'h00; ld = 1; step(); ld = 0;
    start = 1; amt = 4; dir = 1; mode = 2'b11; step(); start = 0;
    si = 1; step();
    si = 0; step();
    si = 1; step();
    si = 1; step();
    chk("ser_q", q, 8'h0B);
    chk("ser_done", done, 1);
    chk("ser_so", so, 0);

    // amt = 0
    start = 1; amt = 0; dir = 0; mode = 2'b00; step(); start = 0;
    chk("amt0_busy", busy, 0);
    chk("amt0_done", done, 1);
    chk("amt0_q", q, 8'h0B);
    step();
    chk("amt0_done_pulse", done, 0);
    chk("amt0_busy2", busy, 0);

    // ld has priority over start
    d = 8'h55; ld = 1; start = 1; amt = 3; step(); ld = 0; start = 0;
    chk("ldst_q", q, 8'h55);
    chk("ldst_busy", busy, 0);
    step();
    chk("ldst_done", done, 0);
    chk("ldst_q_hold", q, 8'h55);

    // ld / dir / mode changes ignored while busy
    start = 1; amt = 2; dir = 0; mode = 2'b00; step(); start = 0;
    ld = 1; d = 8'hFF; dir = 1; mode = 2'b10; step(); ld = 0;
    chk("busy_ld_q", q, 8'h2A);
    chk("busy_ld_so", so, 1);
    step();
    chk("busy_ld_q2", q, 8'h15);
    chk("busy_ld_so2", so, 0);
    chk("busy_ld_done", done, 1);

    // reset during a 5-step shift, after two shifts
    start = 1; amt = 5; dir = 1; mode = 2'b00; step(); start = 0;
    step();
    chk("mid_e1_q", q, 8'h2A);
    step();
    chk("mid_e2_q", q, 8'h54);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_q", q, 8'hA5);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    #1 rst_b = 1'b1;
    step();
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_q", q, 8'hA5);

    // back-to-back single-step operations
    start = 1; amt = 1; dir = 0; mode = 2'b01; step();
    chk("bb1_busy", busy, 1);
    start = 0; step();
    chk("bb1_q", q, 8'hD2);
    chk("bb1_so", so, 1);
    chk("bb1_done", done, 1);
    start = 1; amt = 1; dir = 0; mode = 2'b00; step(); start = 0;
    chk("bb2_busy", busy, 1);
    chk("bb2_q_e0", q, 8'hD2);
    step();
    chk("bb2_q", q, 8'h69);
    chk("bb2_so", so, 0);
    chk("bb2_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
